line_steer_ctrl: RTL
====================

// Module: line_steer_ctrl
// PURPOSE
//  Consumes the debounced 8-bit line-sensor vector and drives two motor PWM outputs (left/right wheel).
//  Computes a signed line-position error, runs a FOLLOW/SEARCH/STOP state machine and generates glitch-free PWM.
//  Sits directly downstream of the sensor debouncer and directly upstream of the motor driver pins.
// PARAMETERS
//  PWM_BITS    8      width of PWM counter and duty registers
//  BASE_DUTY   160    straight-line duty for both wheels (also pivot duty in SEARCH)
//  TURN_STEP   20     duty change per unit of position error
//  TICK_DIV    1000   SCLK cycles per control tick (sensor sample / state update rate)
//  LOST_TICKS  500    ticks in SEARCH without reacquiring the line before giving up
// PORTS
//  SCLK       in   1         system clock, all logic on rising edge
//  RST_N      in   1         asynchronous active-low reset
//  SENSE      in   8         debounced sensors; 1 = line seen; bit7 = leftmost, bit0 = rightmost
//  ENABLE     in   1         run request; low forces IDLE
//  PWM_L      out  1         left wheel PWM
//  PWM_R      out  1         right wheel PWM
//  NAV_STATE  out  2         current state encoding (IDLE=0 FOLLOW=1 SEARCH=2 STOP=3)
//  LOST       out  1         sticky: STOP reached via SEARCH timeout
// BEHAVIOUR
//  Reset: state IDLE; tick counter, lost counter, PWM counter = 0; duty_L/duty_R (active and pending) = 0;
//   PWM_L=PWM_R=0; LOST=0; last_side=right.
//  Tick: counter counts 0..TICK_DIV-1 and pulses tick on TICK_DIV-1. SENSE is sampled only on tick.
//  Error: Wl = 4*S7+3*S6+2*S5+1*S4; Wr = 1*S3+2*S2+3*S1+4*S0; err = Wr-Wl, signed, range -10..+10.
//   pend_L = sat(BASE_DUTY + err*TURN_STEP); pend_R = sat(BASE_DUTY - err*TURN_STEP).
//   Intermediate width PWM_BITS+6 signed; saturate to [0, 2^PWM_BITS-1].
//   last_side updates on every FOLLOW tick with err!=0: err>0 -> right, err<0 -> left.
//  States (transitions on tick unless noted):
//   IDLE:   pend duties 0. ENABLE=1 -> FOLLOW.
//   FOLLOW: SENSE=8'hFF -> STOP, pend 0 (finish/intersection). SENSE=0 -> SEARCH, clear lost counter.
//           Otherwise stay; pend from err.
//   SEARCH: pivot toward last_side: right -> pend_L=BASE, pend_R=0; left -> pend_L=0, pend_R=BASE.
//           SENSE=FF -> STOP. SENSE nonzero -> FOLLOW, pend from err the same tick.
//           Otherwise increment lost counter; on reaching LOST_TICKS -> STOP and set LOST=1.
//   STOP:   pend 0. Leaves only via ENABLE low.
//   ENABLE low in any state -> IDLE on the next SCLK edge, not tick-gated. Pend 0 and LOST cleared.
//  Simultaneous: ENABLE low takes priority over any tick transition. In SEARCH, FF checked before nonzero,
//   nonzero checked before timeout.
//  PWM: free-running PWM_BITS counter increments every cycle and wraps.
//   PWM_x registered = (pwm_cnt < duty_x). Duty 0 -> constant low; max duty -> high 255 of 256 cycles.
//  Active duty_x loads from pend_x only on the cycle pwm_cnt = all-ones. No partial or glitched PWM periods.
//   Exception: entering IDLE via ENABLE low also zeroes active duties immediately.
//  Latency: tick -> NAV_STATE/pend 1 cycle; pend -> PWM output at the next PWM period start.
//  Reset asserted mid-period: outputs low asynchronously; no pending duty survives.
// TESTING (bench uses TICK_DIV=4, LOST_TICKS=3, defaults otherwise)
//  Reset, ENABLE=1, SENSE=8'h18 -> FOLLOW after first tick; err=0; PWM_L=PWM_R high 160/256 cycles.
//  SENSE=8'h0C -> err=+3; duty_L=220, duty_R=100; change lands only at the PWM wrap.
//   SENSE=8'h03 -> err=+7; duty_L=255 (saturated), duty_R=20.
//  After 8'h03, SENSE=0 -> SEARCH right pivot: L=160, R=0. Hold 3 ticks -> STOP, LOST=1, both PWM low.
//  SEARCH entered with last_side=left, SENSE=8'h40 on 2nd tick -> FOLLOW; err=-3, duty_L=100, duty_R=220; LOST=0.
//  FOLLOW, SENSE=8'hFF -> STOP. Drop ENABLE mid-PWM-period -> IDLE next cycle, PWM low same cycle, LOST=0.
//  Assert RST_N=0 asynchronously mid-FOLLOW -> NAV_STATE=0, PWM_L=PWM_R=0 without waiting for an SCLK edge.

Source files
------------

// File: rtl/line_steer_ctrl.sv
// line_steer_ctrl
//   Line-follower steering controller. Turns the debounced 8-bit sensor
//   vector into a signed position error, runs an IDLE/FOLLOW/SEARCH/STOP
//   navigation state machine on a slow control tick, and drives two
//   glitch-free PWM outputs for the left and right wheels.
//
// Ports
//   SCLK       in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   SENSE      in   [7:0] debounced sensors, 1 = line; bit7 leftmost, bit0 rightmost
//   ENABLE     in   run request; low forces IDLE on the next clock edge
//   PWM_L      out  left wheel PWM
//   PWM_R      out  right wheel PWM
//   NAV_STATE  out  [1:0] IDLE=0 FOLLOW=1 SEARCH=2 STOP=3
//   LOST       out  sticky flag: STOP was reached through a SEARCH timeout
module line_steer_ctrl #(
  parameter int PWM_BITS   = 8,
  parameter int BASE_DUTY  = 160,
  parameter int TURN_STEP  = 20,
  parameter int TICK_DIV   = 1000,
  parameter int LOST_TICKS = 500
) (
  input  logic       SCLK,
  input  logic       RST_N,
  input  logic [7:0] SENSE,
  input  logic       ENABLE,
  output logic       PWM_L,
  output logic       PWM_R,
  output logic [1:0] NAV_STATE,
  output logic       LOST
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = $clog2(LOST_TICKS + 1);
  localparam int EW = PWM_BITS + 6;

  localparam logic [TW-1:0]        TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0]        LOST_LAST  = LW'(LOST_TICKS);
  localparam logic signed [EW-1:0] BASE_S     = EW'(BASE_DUTY);
  localparam logic signed [EW-1:0] STEP_S     = EW'(TURN_STEP);
  localparam logic signed [EW-1:0] DUTY_MAX_S = EW'((1 << PWM_BITS) - 1);
  localparam logic [PWM_BITS-1:0]  BASE_D     = PWM_BITS'(BASE_DUTY);
  localparam logic [PWM_BITS-1:0]  DUTY_MAX   = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FOLLOW = 2'd1;
  localparam logic [1:0] ST_SEARCH = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  logic [TW-1:0]       tick_cnt_q;
  logic                tick;
  logic [1:0]          state_q, state_d;
  logic [LW-1:0]       lost_cnt_q, lost_cnt_d, lost_inc;
  logic                lost_q, lost_d;
  logic                side_q, side_d;
  logic [PWM_BITS-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [PWM_BITS-1:0] duty_l_q, duty_r_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                pwm_l_q, pwm_r_q;

  logic [3:0]           wl, wr;
  logic signed [EW-1:0] err_s, sum_l, sum_r;
  logic [PWM_BITS-1:0]  err_l, err_r;

  function automatic logic [PWM_BITS-1:0] sat(input logic signed [EW-1:0] v);
    if (v < 0)
      return '0;
    else if (v > DUTY_MAX_S)
      return DUTY_MAX;
    else
      return v[PWM_BITS-1:0];
  endfunction

  // Control tick divider; free-running so the tick phase is fixed from reset.
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N)
      tick_cnt_q <= '0;
    else if (tick)
      tick_cnt_q <= '0;
    else
      tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  // Weighted position error: positive means the line sits to the right.
  always_comb begin
    wl = (SENSE[7] ? 4'd4 : 4'd0) + (SENSE[6] ? 4'd3 : 4'd0) +
         (SENSE[5] ? 4'd2 : 4'd0) + (SENSE[4] ? 4'd1 : 4'd0);
    wr = (SENSE[3] ? 4'd1 : 4'd0) + (SENSE[2] ? 4'd2 : 4'd0) +
         (SENSE[1] ? 4'd3 : 4'd0) + (SENSE[0] ? 4'd4 : 4'd0);
    err_s = EW'(wr) - EW'(wl);
    sum_l = BASE_S + err_s * STEP_S;
    sum_r = BASE_S - err_s * STEP_S;
    err_l = sat(sum_l);
    err_r = sat(sum_r);
  end

  assign lost_inc = lost_cnt_q + LW'(1);

  // Navigation state machine. ENABLE low overrides everything without
  // waiting for a tick; all other decisions happen only on a tick.
  always_comb begin
    state_d    = state_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    lost_cnt_d = lost_cnt_q;
    lost_d     = lost_q;
    side_d     = side_q;
    if (!ENABLE) begin
      state_d    = ST_IDLE;
      pend_l_d   = '0;
      pend_r_d   = '0;
      lost_d     = 1'b0;
      lost_cnt_d = '0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          pend_l_d = '0;
          pend_r_d = '0;
          state_d  = ST_FOLLOW;
        end
        ST_FOLLOW: begin
          if (SENSE == 8'hFF) begin
            state_d  = ST_STOP;
            pend_l_d = '0;
            pend_r_d = '0;
          end else if (SENSE == 8'h00) begin
            // Line lost: start pivoting right away toward where it was last seen.
            state_d    = ST_SEARCH;
            lost_cnt_d = '0;
            pend_l_d   = (side_q == SIDE_RIGHT) ? BASE_D : '0;
            pend_r_d   = (side_q == SIDE_RIGHT) ? '0 : BASE_D;
          end else begin
            pend_l_d = err_l;
            pend_r_d = err_r;
            if (err_s > 0)
              side_d = SIDE_RIGHT;
            else if (err_s < 0)
              side_d = SIDE_LEFT;
          end
        end
        ST_SEARCH: begin
          if (SENSE == 8'hFF) begin
            state_d  = ST_STOP;
            pend_l_d = '0;
            pend_r_d = '0;
          end else if (SENSE != 8'h00) begin
            state_d  = ST_FOLLOW;
            pend_l_d = err_l;
            pend_r_d = err_r;
          end else if (lost_inc == LOST_LAST) begin
            state_d    = ST_STOP;
            lost_d     = 1'b1;
            lost_cnt_d = lost_inc;
            pend_l_d   = '0;
            pend_r_d   = '0;
          end else begin
            lost_cnt_d = lost_inc;
            pend_l_d   = (side_q == SIDE_RIGHT) ? BASE_D : '0;
            pend_r_d   = (side_q == SIDE_RIGHT) ? '0 : BASE_D;
          end
        end
        default: begin
          pend_l_d = '0;
          pend_r_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      lost_cnt_q <= '0;
      lost_q     <= 1'b0;
      side_q     <= SIDE_RIGHT;
      pend_l_q   <= '0;
      pend_r_q   <= '0;
    end else begin
      state_q    <= state_d;
      lost_cnt_q <= lost_cnt_d;
      lost_q     <= lost_d;
      side_q     <= side_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
    end
  end

  // PWM engine. Active duties only change at the counter wrap so every
  // period is whole; dropping ENABLE kills the duties and outputs at once.
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm_cnt_q <= '0;
      duty_l_q  <= '0;
      duty_r_q  <= '0;
      pwm_l_q   <= 1'b0;
      pwm_r_q   <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      if (!ENABLE) begin
        duty_l_q <= '0;
        duty_r_q <= '0;
      end else if (pwm_cnt_q == DUTY_MAX) begin
        duty_l_q <= pend_l_q;
        duty_r_q <= pend_r_q;
      end
      pwm_l_q <= ENABLE && (pwm_cnt_q < duty_l_q);
      pwm_r_q <= ENABLE && (pwm_cnt_q < duty_r_q);
    end
  end

  assign PWM_L     = pwm_l_q;
  assign PWM_R     = pwm_r_q;
  assign NAV_STATE = state_q;
  assign LOST      = lost_q;

endmodule
